// File: rtl/pll_md_pkg.sv
// Shared definitions for the PLL MD-bus responder: opcodes, data width,
// lock-state encoding and the register-file reset image.
package pll_md_pkg;

  localparam int MD_DATA_W = 8;

  typedef logic [1:0] md_opc_t;

  localparam md_opc_t MD_NOP   = 2'b00;
  localparam md_opc_t MD_ADDR  = 2'b01;
  localparam md_opc_t MD_WRITE = 2'b10;
  localparam md_opc_t MD_READ  = 2'b11;

  typedef enum logic {
    RESET_WAIT = 1'b0,
    LOCKED     = 1'b1
  } lock_state_e;

  // Power-on contents of the emulated PLL register file.
  function automatic logic [MD_DATA_W-1:0] REG_DEFAULT(input int unsigned addr);
    return (addr == 0) ? 8'h0F : 8'h00;
  endfunction

endpackage

// File: rtl/pll_md_responder_if.sv
// MD configuration bus between the PLL init master and the responder.
// wr_err exists only when PLL_MD_WRPROT_EN is defined.
interface pll_md_responder_if;
  import pll_md_pkg::*;

  md_opc_t                mdopc;
  logic                   mdainc;
  logic [MD_DATA_W-1:0]   mdwdi;
  logic [MD_DATA_W-1:0]   mdrdo;
  logic                   lock;
`ifdef PLL_MD_WRPROT_EN
  logic                   wr_err;
`endif

  modport master (
    output mdopc, mdainc, mdwdi,
    input  mdrdo, lock
`ifdef PLL_MD_WRPROT_EN
    , input wr_err
`endif
  );

  modport slave (
    input  mdopc, mdainc, mdwdi,
    output mdrdo, lock
`ifdef PLL_MD_WRPROT_EN
    , output wr_err
`endif
  );

endinterface

// File: rtl/pll_md_lock_timer.sv
// Emulated PLL lock: lock asserts LOCK_CYCLES edges after the last restart
// (reset or accepted WRITE); a restart always wins over the terminal count.
module pll_md_lock_timer
  import pll_md_pkg::*;
#(
  parameter int LOCK_CYCLES = 1000
) (
  input  logic mdclk,
  input  logic reset,
  input  logic restart,
  output logic lock
);

  localparam int                CNT_W   = $clog2(LOCK_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_TC  = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  lock_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (restart) begin
      state_d = RESET_WAIT;
      cnt_d   = '0;
    end else if (state_q == RESET_WAIT && cnt_q == CNT_TC) begin
      state_d = LOCKED;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge mdclk) begin
    if (reset) begin
      state_q <= RESET_WAIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lock = (state_q == LOCKED);

endmodule

// File: rtl/pll_md_responder.sv
// PLL MD-bus responder: register file, auto-incrementing address pointer,
// registered read data and emulated lock. Optional write protection of
// addresses >= RO_BASE is enabled by defining PLL_MD_WRPROT_EN.
module pll_md_responder
  import pll_md_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int LOCK_CYCLES = 1000
`ifdef PLL_MD_WRPROT_EN
  , parameter int RO_BASE   = 48
`endif
) (
  input  logic                mdclk,
  input  logic                reset,
  pll_md_responder_if.slave   md
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [MD_DATA_W-1:0]  rdo_q, rdo_d;
  logic [MD_DATA_W-1:0]  mem_q [DEPTH];
  logic                  wr_req;
  logic                  wr_ok;
  logic                  wr_en;

  always_comb begin
    addr_d = addr_q;
    rdo_d  = rdo_q;
    wr_req = 1'b0;
    case (md.mdopc)
      MD_ADDR: addr_d = md.mdwdi[ADDR_W-1:0];
      MD_WRITE: begin
        wr_req = 1'b1;
        if (md.mdainc) addr_d = addr_q + ADDR_W'(1);
      end
      MD_READ: begin
        rdo_d = mem_q[addr_q];
        if (md.mdainc) addr_d = addr_q + ADDR_W'(1);
      end
      default: ;
    endcase
  end

`ifdef PLL_MD_WRPROT_EN
  localparam logic [ADDR_W-1:0] RO_BASE_A = ADDR_W'(RO_BASE);

  logic wr_err_q;

  assign wr_ok = (addr_q < RO_BASE_A);

  // Sticky until reset; a blocked write still advances the address above.
  always_ff @(posedge mdclk) begin
    if (reset) begin
      wr_err_q <= 1'b0;
    end else if (wr_req && !wr_ok) begin
      wr_err_q <= 1'b1;
    end
  end

  assign md.wr_err = wr_err_q;
`else
  assign wr_ok = 1'b1;
`endif

  assign wr_en = wr_req & wr_ok;

  always_ff @(posedge mdclk) begin
    if (reset) begin
      addr_q <= '0;
      rdo_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rdo_q  <= rdo_d;
    end
  end

  // NOTE: the register file is deliberately reset to the REG_DEFAULT image,
  // so it is built from flops rather than a RAM macro.
  always_ff @(posedge mdclk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= REG_DEFAULT(i);
      end
    end else if (wr_en) begin
      mem_q[addr_q] <= md.mdwdi;
    end
  end

  pll_md_lock_timer #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock_timer (
    .mdclk   (mdclk),
    .reset   (reset),
    .restart (wr_en),
    .lock    (md.lock)
  );

  assign md.mdrdo = rdo_q;

endmodule

// File: tb/tb_pll_md_responder.sv
// Self-checking bench for pll_md_responder (ADDR_W=6, LOCK_CYCLES=8): lock
// timing sequences, table-driven bus vectors and a read-data scoreboard.
module tb_pll_md_responder;
  import pll_md_pkg::*;

  typedef struct packed {
    md_opc_t     opc;
    logic        ainc;
    logic [7:0]  wdi;
    logic [7:0]  exp_rdo;
  } vec_t;

  logic mdclk = 1'b0;
  logic reset = 1'b1;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_rd = 8'h00;
  vec_t       vecs[$];

  pll_md_responder_if md_if ();

  pll_md_responder #(
    .ADDR_W      (6),
    .LOCK_CYCLES (8)
  ) dut (
    .mdclk (mdclk),
    .reset (reset),
    .md    (md_if.slave)
  );

  always #5 mdclk = ~mdclk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required: finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one bus cycle at the falling edge, then sample #1 after the rising edge.
  task automatic step(input md_opc_t opc, input logic ainc, input logic [7:0] wdi);
    @(negedge mdclk);
    reset        = 1'b0;
    md_if.mdopc  = opc;
    md_if.mdainc = ainc;
    md_if.mdwdi  = wdi;
    @(posedge mdclk);
    #1;
  endtask

  task automatic do_read(input logic ainc, input logic [7:0] exp, input string name);
    logic [7:0] e;
    exp_q.push_back(exp);
    step(MD_READ, ainc, 8'h00);
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check(name, int'(md_if.mdrdo), int'(e));
      last_rd = e;
    end
  endtask

  // Count NOP cycles until lock rises; -1 if it never does within the bound.
  task automatic wait_lock(output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      step(MD_NOP, 1'b0, 8'h00);
      if (md_if.lock === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;

    vecs.push_back('{MD_ADDR,  1'b0, 8'h05, 8'h00});
    vecs.push_back('{MD_WRITE, 1'b1, 8'hA1, 8'h00});
    vecs.push_back('{MD_WRITE, 1'b1, 8'hB2, 8'h00});
    vecs.push_back('{MD_WRITE, 1'b1, 8'hC3, 8'h00});
    vecs.push_back('{MD_ADDR,  1'b1, 8'h05, 8'h00});
    vecs.push_back('{MD_READ,  1'b1, 8'h00, 8'hA1});
    vecs.push_back('{MD_READ,  1'b1, 8'h00, 8'hB2});
    vecs.push_back('{MD_READ,  1'b1, 8'h00, 8'hC3});
    vecs.push_back('{MD_NOP,   1'b1, 8'h00, 8'h00});
    vecs.push_back('{MD_ADDR,  1'b0, 8'h3F, 8'h00});
    vecs.push_back('{MD_WRITE, 1'b1, 8'h5A, 8'h00});
    vecs.push_back('{MD_READ,  1'b0, 8'h00, 8'h0F});
    vecs.push_back('{MD_ADDR,  1'b0, 8'h3F, 8'h00});
    vecs.push_back('{MD_READ,  1'b0, 8'h00, 8'h5A});
    vecs.push_back('{MD_ADDR,  1'b0, 8'h0A, 8'h00});
    vecs.push_back('{MD_WRITE, 1'b0, 8'h77, 8'h00});
    vecs.push_back('{MD_READ,  1'b0, 8'h00, 8'h77});
    vecs.push_back('{MD_READ,  1'b0, 8'h00, 8'h77});

    // Reset for two edges with a WRITE on the bus; it must be discarded.
    md_if.mdopc  = MD_WRITE;
    md_if.mdainc = 1'b1;
    md_if.mdwdi  = 8'hFF;
    reset        = 1'b1;
    @(posedge mdclk);
    @(posedge mdclk);
    #1;
    check("reset_mdrdo", int'(md_if.mdrdo), 8'h00);
    check("reset_lock", int'(md_if.lock), 0);
`ifdef PLL_MD_WRPROT_EN
    check("reset_wr_err", int'(md_if.wr_err), 0);
`endif

    wait_lock(n);
    check("lock_after_reset_cycles", n, 8);
    do_read(1'b0, 8'h0F, "rd_addr0_default");
    step(MD_ADDR, 1'b0, 8'h01);
    do_read(1'b0, 8'h00, "rd_addr1_default");

    // WRITE drops lock; a second WRITE 5 cycles later restarts the settle time.
    step(MD_ADDR, 1'b0, 8'h14);
    check("lock_held_over_addr", int'(md_if.lock), 1);
    step(MD_WRITE, 1'b0, 8'h11);
    check("lock_drop_on_write", int'(md_if.lock), 0);
    for (int i = 0; i < 4; i++) step(MD_NOP, 1'b0, 8'h00);
    step(MD_WRITE, 1'b0, 8'h22);
    check("lock_low_second_write", int'(md_if.lock), 0);
    wait_lock(n);
    check("lock_after_second_write", n, 8);

    // WRITE landing on the terminal-count cycle keeps lock low.
    step(MD_WRITE, 1'b0, 8'h33);
    for (int i = 0; i < 7; i++) step(MD_NOP, 1'b0, 8'h00);
    check("lock_low_before_tc", int'(md_if.lock), 0);
    step(MD_WRITE, 1'b0, 8'h44);
    check("lock_write_wins_tc", int'(md_if.lock), 0);
    wait_lock(n);
    check("lock_after_tc_write", n, 8);
    do_read(1'b0, 8'h44, "rd_addr20");

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].opc == MD_READ) begin
        do_read(vecs[i].ainc, vecs[i].exp_rdo, $sformatf("vec%0d_rd", i));
      end else begin
        step(vecs[i].opc, vecs[i].ainc, vecs[i].wdi);
        check($sformatf("vec%0d_hold", i), int'(md_if.mdrdo), int'(last_rd));
      end
    end

`ifdef PLL_MD_WRPROT_EN
    wait_lock(n);
    check("wp_lock_reached", int'(n > 0), 1);
    step(MD_ADDR, 1'b0, 8'h32);
    step(MD_WRITE, 1'b0, 8'hEE);
    check("wp_wr_err_set", int'(md_if.wr_err), 1);
    check("wp_lock_kept", int'(md_if.lock), 1);
    step(MD_NOP, 1'b0, 8'h00);
    check("wp_wr_err_sticky", int'(md_if.wr_err), 1);
    do_read(1'b0, 8'h00, "wp_rd_addr50_unchanged");
    step(MD_ADDR, 1'b0, 8'h0A);
    step(MD_WRITE, 1'b0, 8'h10);
    check("wp_rw_write_drops_lock", int'(md_if.lock), 0);
    check("wp_wr_err_still", int'(md_if.wr_err), 1);
    do_read(1'b0, 8'h10, "wp_rd_addr10");
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
